// File: rtl/spi_operand_rx.sv
// SPI-slave (mode 0) front end for the 4-bit adder: deserialises {cin, a, b} into
// registered operands with a valid strobe, and returns the captured {c_out, sum} on MISO.
module spi_operand_rx #(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sclk,
  input  logic         cs_n,
  input  logic         mosi,
  output logic         miso,
  input  logic [W-1:0] sum,
  input  logic         c_out,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         op_cin,
  output logic         op_valid,
  output logic         frame_err
);

  localparam int FRAME_LEN = 2 * W + 1;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  logic [SYNC_STAGES:0]   w_sclk_chain;
  logic [SYNC_STAGES:0]   w_cs_chain;
  logic [SYNC_STAGES:0]   w_mosi_chain;
  logic                   w_sclk_s;
  logic                   w_cs_s;
  logic                   w_mosi_s;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_cs_rise;
  logic                   w_cs_fall;

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [2*W-1:0]         r_rx_shift;
  logic [2*W:0]           r_tx_shift;
  logic [W:0]             r_result_reg;
  logic [2*W:0]           w_frame;

  // Stage p0: input synchronisers. cs_n resets low so a frame already in flight is never entered.
  assign w_sclk_chain = {r_sclk_sync, sclk};
  assign w_cs_chain   = {r_cs_sync, cs_n};
  assign w_mosi_chain = {r_mosi_sync, mosi};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= w_sclk_chain[SYNC_STAGES-1:0];
      r_cs_sync   <= w_cs_chain[SYNC_STAGES-1:0];
      r_mosi_sync <= w_mosi_chain[SYNC_STAGES-1:0];
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign w_cs_rise   = w_cs_s & ~r_cs_prev;
  assign w_cs_fall   = ~w_cs_s & r_cs_prev;

  // The final bit is taken straight from the synchroniser so operands land on the last rise.
  assign w_frame = {r_rx_shift, w_mosi_s};

  // Stage p1: frame FSM, operand registers and result shift-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      op_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      op_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_bit_cnt  <= '0;
          r_tx_shift <= {r_result_reg, {W{1'b0}}};
          if (w_cs_fall) begin
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_cs_rise) begin
            // A deselect coincident with the last rise still completes the frame.
            if (w_sclk_rise && (r_bit_cnt == LAST_IDX)) begin
              op_cin   <= w_frame[2*W];
              op_a     <= w_frame[2*W-1:W];
              op_b     <= w_frame[W-1:0];
              op_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end else if (w_sclk_rise) begin
            r_rx_shift <= w_frame[2*W-1:0];
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_IDX) begin
              op_cin   <= w_frame[2*W];
              op_a     <= w_frame[2*W-1:W];
              op_b     <= w_frame[W-1:0];
              op_valid <= 1'b1;
              r_state  <= S_HOLD;
            end
          end else if (w_sclk_fall) begin
            r_tx_shift <= {r_tx_shift[2*W-1:0], 1'b0};
          end
        end
        S_HOLD: begin
          r_tx_shift <= '0;
          if (w_cs_rise) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stage p2: the adder settles during the op_valid cycle; capture its output at the end of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result_reg <= '0;
    end else if (op_valid) begin
      r_result_reg <= {c_out, sum};
    end
  end

  assign miso = ~w_cs_s & r_tx_shift[2*W];

endmodule

// File: tb/tb_spi_operand_rx.sv
// Directed bench for spi_operand_rx: bit-banged SPI master plus a behavioural 4-bit adder.
module tb_spi_operand_rx;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [3:0] sum;
  logic       c_out;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_cin;
  logic       op_valid;
  logic       frame_err;
  logic [4:0] w_add;

  int n_vec = 0;
  int n_err = 0;

  int         vcnt = 0;
  int         ecnt = 0;
  logic [8:0] cap_ops = '0;
  logic [4:0] cap_res = '0;
  logic       vld_prev = 1'b0;

  spi_operand_rx #(.W(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .sum(sum), .c_out(c_out), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .op_valid(op_valid), .frame_err(frame_err)
  );

  assign w_add = {1'b0, op_a} + {1'b0, op_b} + {4'b0, op_cin};
  assign sum   = w_add[3:0];
  assign c_out = w_add[4];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (op_valid) begin
      vcnt    <= vcnt + 1;
      cap_ops <= {op_cin, op_a, op_b};
    end
    if (frame_err) ecnt <= ecnt + 1;
    if (vld_prev) cap_res <= dut.r_result_reg;
    vld_prev <= op_valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_start();
    cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    wait_clks(HALF);
    m = miso;
    sclk = 1'b1;
    wait_clks(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_end();
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(3 * HALF);
  endtask

  task automatic send_frame(input logic [8:0] f, output logic [8:0] m);
    logic bm;
    spi_start();
    for (int i = 8; i >= 0; i--) begin
      spi_bit(f[i], bm);
      m[i] = bm;
    end
    spi_end();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(4);
    n_vec++;
    if ({op_cin, op_a, op_b} !== 9'd0) begin
      n_err++; $display("FAIL reset_ops: got %h want 000", {op_cin, op_a, op_b});
    end
    n_vec++;
    if ({op_valid, frame_err} !== 2'b00) begin
      n_err++; $display("FAIL reset_strobes: got %b want 00", {op_valid, frame_err});
    end
    n_vec++;
    if (miso !== 1'b0) begin
      n_err++; $display("FAIL reset_miso: got %b want 0", miso);
    end
    n_vec++;
    if (dut.r_result_reg !== 5'd0) begin
      n_err++; $display("FAIL reset_result: got %h want 00", dut.r_result_reg);
    end
    rst = 1'b0;
    wait_clks(8);
  endtask

  task automatic test_frame_basic();
    int v0 = vcnt;
    int e0 = ecnt;
    logic [8:0] m;
    send_frame(9'b0_0010_0010, m);
    n_vec++;
    if ((vcnt - v0) !== 1 || (ecnt - e0) !== 0) begin
      n_err++; $display("FAIL basic_strobes: valid %0d err %0d want 1 0", vcnt - v0, ecnt - e0);
    end
    n_vec++;
    if (cap_ops !== 9'b0_0010_0010) begin
      n_err++; $display("FAIL basic_ops_at_valid: got %h want 022", cap_ops);
    end
    n_vec++;
    if ({op_cin, op_a, op_b} !== 9'b0_0010_0010) begin
      n_err++; $display("FAIL basic_ops_held: got %h want 022", {op_cin, op_a, op_b});
    end
    n_vec++;
    if (cap_res !== 5'b0_0100) begin
      n_err++; $display("FAIL basic_result: got %b want 00100", cap_res);
    end
  endtask

  task automatic test_miso_second();
    logic [8:0] m;
    send_frame(9'b0_1111_0001, m);
    n_vec++;
    if (m !== 9'b001000000) begin
      n_err++; $display("FAIL second_miso: got %b want 001000000", m);
    end
    n_vec++;
    if (cap_ops !== 9'b0_1111_0001) begin
      n_err++; $display("FAIL second_ops: got %h want 0f1", cap_ops);
    end
    n_vec++;
    if (cap_res !== 5'b1_0000) begin
      n_err++; $display("FAIL second_result: got %b want 10000", cap_res);
    end
  endtask

  task automatic test_miso_third();
    logic [8:0] m;
    send_frame(9'b0_0011_0100, m);
    n_vec++;
    if (m !== 9'b100000000) begin
      n_err++; $display("FAIL third_miso: got %b want 100000000", m);
    end
    n_vec++;
    if (cap_res !== 5'b0_0111) begin
      n_err++; $display("FAIL third_result: got %b want 00111", cap_res);
    end
  endtask

  task automatic test_short_frame();
    int v0 = vcnt;
    int e0 = ecnt;
    logic [4:0] bits = 5'b1_0011;
    logic bm;
    spi_start();
    for (int i = 4; i >= 0; i--) spi_bit(bits[i], bm);
    spi_end();
    n_vec++;
    if ((ecnt - e0) !== 1) begin
      n_err++; $display("FAIL short_frame_err: got %0d pulses want 1", ecnt - e0);
    end
    n_vec++;
    if ((vcnt - v0) !== 0) begin
      n_err++; $display("FAIL short_no_valid: got %0d pulses want 0", vcnt - v0);
    end
    n_vec++;
    if ({op_cin, op_a, op_b} !== 9'b0_0011_0100) begin
      n_err++; $display("FAIL short_ops_held: got %h want 034", {op_cin, op_a, op_b});
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0 = vcnt;
    int e0 = ecnt;
    logic [8:0] pre = 9'b1_1100_1100;
    logic [8:0] m;
    logic bm;
    spi_start();
    for (int i = 8; i >= 5; i--) spi_bit(pre[i], bm);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    for (int i = 4; i >= 0; i--) spi_bit(pre[i], bm);
    spi_end();
    n_vec++;
    if ((vcnt - v0) !== 0 || (ecnt - e0) !== 0) begin
      n_err++; $display("FAIL rstmid_strobes: valid %0d err %0d want 0 0", vcnt - v0, ecnt - e0);
    end
    n_vec++;
    if ({op_cin, op_a, op_b} !== 9'd0) begin
      n_err++; $display("FAIL rstmid_ops_cleared: got %h want 000", {op_cin, op_a, op_b});
    end
    v0 = vcnt;
    send_frame(9'b1_0101_1010, m);
    n_vec++;
    if ((vcnt - v0) !== 1 || cap_ops !== 9'b1_0101_1010) begin
      n_err++; $display("FAIL rstmid_next_frame: valid %0d ops %h want 1 15a", vcnt - v0, cap_ops);
    end
    n_vec++;
    if (m !== 9'd0) begin
      n_err++; $display("FAIL rstmid_miso: got %b want 000000000", m);
    end
    n_vec++;
    if (cap_res !== 5'b1_0000) begin
      n_err++; $display("FAIL rstmid_result: got %b want 10000", cap_res);
    end
  endtask

  task automatic test_simultaneous_end();
    int v0 = vcnt;
    int e0 = ecnt;
    logic [8:0] f = 9'b0_0110_0011;
    logic bm;
    spi_start();
    for (int i = 8; i >= 1; i--) spi_bit(f[i], bm);
    mosi = f[0];
    wait_clks(HALF);
    sclk = 1'b1;
    cs_n = 1'b1;
    wait_clks(HALF);
    sclk = 1'b0;
    wait_clks(3 * HALF);
    n_vec++;
    if ((vcnt - v0) !== 1 || (ecnt - e0) !== 0) begin
      n_err++; $display("FAIL simul_strobes: valid %0d err %0d want 1 0", vcnt - v0, ecnt - e0);
    end
    n_vec++;
    if (cap_ops !== 9'b0_0110_0011) begin
      n_err++; $display("FAIL simul_ops: got %h want 063", cap_ops);
    end
    n_vec++;
    if (cap_res !== 5'b0_1001) begin
      n_err++; $display("FAIL simul_result: got %b want 01001", cap_res);
    end
  endtask

  task automatic test_overlong();
    int v0 = vcnt;
    int e0 = ecnt;
    logic [11:0] f = 12'b0_0001_0001_111;
    logic [11:0] m;
    logic bm;
    spi_start();
    for (int i = 11; i >= 0; i--) begin
      spi_bit(f[i], bm);
      m[i] = bm;
    end
    spi_end();
    n_vec++;
    if ((vcnt - v0) !== 1 || (ecnt - e0) !== 0) begin
      n_err++; $display("FAIL overlong_strobes: valid %0d err %0d want 1 0", vcnt - v0, ecnt - e0);
    end
    n_vec++;
    if ({op_cin, op_a, op_b} !== 9'b0_0001_0001) begin
      n_err++; $display("FAIL overlong_ops: got %h want 011", {op_cin, op_a, op_b});
    end
    n_vec++;
    if (m[11:3] !== 9'b010010000) begin
      n_err++; $display("FAIL overlong_miso_frame: got %b want 010010000", m[11:3]);
    end
    n_vec++;
    if (m[2:0] !== 3'b000) begin
      n_err++; $display("FAIL overlong_miso_extra: got %b want 000", m[2:0]);
    end
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_miso_second();
    test_miso_third();
    test_short_frame();
    test_reset_mid_frame();
    test_simultaneous_end();
    test_overlong();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_operand_rx.md
# spi_operand_rx

SPI-slave front end for the controller's 4-bit adder datapath. It receives one serial frame per operation carrying carry-in and both operands, and presents them as registered parallel operands with a one-cycle valid strobe to the downstream `adder_4bit`. It captures the adder's combinational result and shifts it back to the SPI master during the following frame. All SPI inputs are asynchronous to `clk` and are oversampled.

## Interface
- `W`, default 4: operand width. Frame length is 2·W+1 bits; the result is W+1 bits.
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `cs_n` and `mosi`.

Ports:
- `clk`  in  1  system clock. There is one clock.
- `rst`  in  1  reset; synchronous and active-high.
- `sclk`  in  1  SPI clock (mode 0), asynchronous.
- `cs_n`  in  1  SPI chip select, active-low, asynchronous.
- `mosi`  in  1  SPI data in, MSB first.
- `miso`  out  1  SPI data out, MSB first.
- `sum`  in  W  adder sum output.
- `c_out`  in  1  adder carry output.
- `op_a`  out  W  operand A to the adder.
- `op_b`  out  W  operand B to the adder.
- `op_cin`  out  1  carry-in to the adder.
- `op_valid`  out  1  one-cycle strobe; the operands were updated this cycle.
- `frame_err`  out  1  one-cycle strobe; the frame was aborted short.

## Operation
- Frame order (MSB first): `cin`, `a[W-1:0]`, `b[W-1:0]`. For W=4 that is 9 bits.
- Synchronizers:
  - `SYNC_STAGES`-flop synchronizers on all three SPI inputs.
  - Edge detection on the synchronized `sclk` and `cs_n`.
  - The `cs_n` synchronizer resets to 0, so a frame already in progress at reset release is never entered.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE:
    - On a synchronized `cs_n` falling edge, go to SHIFT.
    - Clear `bit_cnt`.
    - Load `tx_shift` ← {`result_reg`, W'b0}.
  - SHIFT, on an `sclk` rise:
    - `rx_shift` ← {`rx_shift`[2W-1:0], `mosi_s`}.
    - `bit_cnt`++.
  - SHIFT, on the rise that makes `bit_cnt` = 2W+1:
    - Transfer `rx_shift` to `op_cin`/`op_a`/`op_b`.
    - Pulse `op_valid`.
    - Go to HOLD.
  - SHIFT, on an `sclk` fall: `tx_shift` ← {`tx_shift`[2W-1:0], 0}.
  - SHIFT, `cs_n` rises with `bit_cnt` < 2W+1: pulse `frame_err`, leave the operands unchanged, go to IDLE.
  - HOLD:
    - Ignore all `sclk` edges; no error is raised for extra edges.
    - `miso` shifts out 0.
    - On a `cs_n` rise, go to IDLE.
- Result capture:
  - `result_reg` ← {`c_out`, `sum`} in the cycle after `op_valid`.
  - This gives the combinational adder one full cycle from the registered operands.
  - `result_reg` holds until the next capture.
- `miso` = `tx_shift`[2W] while `cs_n_s` is low; 0 otherwise. There is no tri-state.
- Operand arithmetic is performed downstream. This block never alters the values, and no width extension is applied.

## Timing
- Reset values:
  - `op_a` = `op_b` = 0.
  - `op_cin` = 0.
  - `op_valid` = 0.
  - `frame_err` = 0.
  - `miso` = 0.
  - `result_reg` = 0.
  - `bit_cnt` = 0.
  - State = IDLE.
- Input latency: the synchronized view lags the pins by `SYNC_STAGES` cycles, plus 1 cycle for edge detection.
- `op_valid` is high for exactly 1 cycle, in the cycle after the final `sclk` rise is detected. The operands are valid in that cycle and hold until the next `op_valid`.
- `result_reg` updates at `op_valid` + 1.
- The first `miso` bit is stable from the `cs_n` fall detection onward, i.e. before the first `sclk` rise (mode 0).
- Subsequent `miso` bits change 1 cycle after an `sclk` fall is detected.
- Requirements on the SPI master:
  - `sclk` high and low phases are each ≥ `SYNC_STAGES`+2 `clk` cycles.
  - `cs_n` setup to the first `sclk` rise is ≥ `SYNC_STAGES`+2 cycles.
- Simultaneous events:
  - A `cs_n` rise in the same cycle as the final `sclk` rise counts as a complete frame: `op_valid` fires, `frame_err` does not.
- Reset mid-frame:
  - Everything returns to reset values, and the partial frame is discarded without `frame_err`.
  - A new frame requires `cs_n` to go high, then low.

## Test plan
- **Frame 0_0010_0010:**
  - One `op_valid` pulse with `op_cin`=0, `op_a`=2, `op_b`=2.
  - Adder model returns 4, so `result_reg`=0_0100 one cycle later.
- **Second frame 0_1111_0001:**
  - `miso` sequence during the frame is 0,0,1,0,0,0,0,0,0.
  - `op_a`=F, `op_b`=1.
  - `result_reg`=1_0000.
- **Third frame (any payload):** `miso` is 1,0,0,0,0,0,0,0,0.
- **Short frame:** `cs_n` rises after 5 bits of 1_0011_xxxx.
  - `frame_err` pulses once.
  - No `op_valid`.
  - `op_a`/`op_b`/`op_cin` unchanged from the previous frame.
- **Reset mid-frame:**
  - `rst` asserted after 4 bits with `cs_n` held low; 5 more bits are then sent and `cs_n` rises.
  - Required: no `op_valid` and no `frame_err`.
  - A following full frame 1_0101_1010 yields `op_cin`=1, `op_a`=5, `op_b`=A.
- **Overlong frame:** 12 `sclk` pulses carrying 0_0001_0001 followed by 111.
  - Exactly one `op_valid`, with `op_a`=1, `op_b`=1, `op_cin`=0.
  - `miso` is 0 after bit 9.
